// File: rtl/lts_sync.sv
// lts_sync: receive-side long-training-symbol synchroniser.
// Correlates {Im,Re} samples against the sign-quantised 64-sample LTS,
// confirms two peaks 64 (+/-TOL) samples apart, then re-emits the data
// samples framed as 80-sample OFDM symbols (16 CP + 64).
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   din/din_vld/din_last   input samples {Im[15:8], Re[7:0]}, no backpressure
//   lts_found          one-cycle pulse when the second peak is confirmed
//   dout/dout_vld/dout_last   post-LTS samples, 2 cycles after acceptance
//   sym_start, dout_index, sym_cnt   symbol framing of each dout beat
// Optional macro LTS_SYNC_DBG_EN adds corr_metric[16:0] (registered metric)
// and peak1 (pulse on each anchor / re-anchor, aligned with corr_metric).

module lts_sync #(
    parameter logic [16:0] THRESH = 17'd2000,
    parameter int unsigned TOL    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        din_last,
    output logic        lts_found,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        dout_last,
    output logic        sym_start,
    output logic [6:0]  dout_index,
    output logic [7:0]  sym_cnt
`ifdef LTS_SYNC_DBG_EN
    ,
    output logic [16:0] corr_metric,
    output logic        peak1
`endif
);

    // Sign tables of the time-domain LTS; bit k set means component of
    // sample k is negative (zero counts as positive).
    localparam logic [63:0] RE_NEG =
        64'b1000_0110_0010_0100_0110_0111_1101_1001_0011_0111_1100_1100_0100_1000_1100_0010;
    localparam logic [63:0] IM_NEG =
        64'b0011_0000_1000_0101_0000_0011_1110_1110_0001_0000_0111_1110_1011_1101_1110_0110;

    localparam logic [7:0] D_LO = 8'(64 - TOL);
    localparam logic [7:0] D_HI = 8'(64 + TOL);
    localparam logic [7:0] D_RA = 8'(63 - TOL - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        PEAK1  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // dl_q[63] is the newest sample, so dl_q[k] is window tap w[k].
    logic [15:0] dl_q [64];

    logic        pv_q, pl_q;
    logic        mv_q, sl_q;
    logic [16:0] m_q, m_d;
    logic [15:0] sd_q;

    state_t      state_q, state_d;
    logic [7:0]  d_q, d_d, dnext;
    logic [16:0] mpk_q, mpk_d;
    logic        anc, fwd, found_d;

    logic [6:0]  idx_q, idx_d;
    logic [7:0]  sym_q, sym_d;

    logic        found_q;
    logic [15:0] dout_q;
    logic        dvld_q, dlast_q, sstart_q;
    logic [6:0]  dix_q;
    logic [7:0]  scnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) begin
                dl_q[k] <= '0;
            end
        end else if (din_vld) begin
            for (int k = 0; k < 63; k++) begin
                dl_q[k] <= dl_q[k + 1];
            end
            dl_q[63] <= din;
        end
    end

    logic signed [15:0] cr, ci, wr, wi;
    logic        [15:0] ar, ai;

    always_comb begin
        cr = '0;
        ci = '0;
        wr = '0;
        wi = '0;
        for (int k = 0; k < 64; k++) begin
            wr = {{8{dl_q[k][7]}}, dl_q[k][7:0]};
            wi = {{8{dl_q[k][15]}}, dl_q[k][15:8]};
            cr = cr + (RE_NEG[k] ? -wr : wr) + (IM_NEG[k] ? -wi : wi);
            ci = ci + (RE_NEG[k] ? -wi : wi) - (IM_NEG[k] ? -wr : wr);
        end
    end

    assign ar  = cr[15] ? 16'(-cr) : 16'(cr);
    assign ai  = ci[15] ? 16'(-ci) : 16'(ci);
    assign m_d = {1'b0, ar} + {1'b0, ai};

    // Stage 1 flags the cycle after acceptance; stage 2 holds the metric
    // together with the sample it belongs to, so the FSM decides on both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q <= 1'b0;
            pl_q <= 1'b0;
            mv_q <= 1'b0;
            sl_q <= 1'b0;
            m_q  <= '0;
            sd_q <= '0;
        end else begin
            pv_q <= din_vld;
            pl_q <= din_vld & din_last;
            mv_q <= pv_q;
            sl_q <= pl_q;
            if (pv_q) begin
                m_q  <= m_d;
                sd_q <= dl_q[63];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        mpk_d   = mpk_q;
        dnext   = d_q + 8'd1;
        anc     = 1'b0;
        fwd     = 1'b0;
        found_d = 1'b0;
        if (mv_q) begin
            unique case (state_q)
                SEARCH: begin
                    if (m_q > THRESH) begin
                        state_d = PEAK1;
                        anc     = 1'b1;
                    end
                end
                PEAK1: begin
                    d_d = dnext;
                    if (dnext >= D_LO && dnext <= D_HI && m_q > THRESH) begin
                        found_d = 1'b1;
                        state_d = LOCKED;
                    end else if (dnext > D_HI) begin
                        state_d = SEARCH;
                    end else if (dnext >= 8'd1 && dnext <= D_RA &&
                                 m_q > THRESH && m_q > mpk_q) begin
                        anc = 1'b1;
                    end
                end
                LOCKED: begin
                    fwd = 1'b1;
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
            if (anc) begin
                d_d   = '0;
                mpk_d = m_q;
            end
            // End of packet always disarms, even on the confirming sample.
            if (sl_q) begin
                state_d = SEARCH;
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        sym_d = sym_q;
        if (fwd) begin
            if (sl_q) begin
                idx_d = '0;
                sym_d = '0;
            end else if (idx_q == 7'd79) begin
                idx_d = '0;
                sym_d = sym_q + 8'd1;
            end else begin
                idx_d = idx_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            d_q      <= '0;
            mpk_q    <= '0;
            idx_q    <= '0;
            sym_q    <= '0;
            found_q  <= 1'b0;
            dout_q   <= '0;
            dvld_q   <= 1'b0;
            dlast_q  <= 1'b0;
            sstart_q <= 1'b0;
            dix_q    <= '0;
            scnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            mpk_q    <= mpk_d;
            idx_q    <= idx_d;
            sym_q    <= sym_d;
            found_q  <= found_d;
            dvld_q   <= fwd;
            dlast_q  <= fwd & sl_q;
            sstart_q <= fwd & (idx_q == 7'd0);
            if (fwd) begin
                dout_q <= sd_q;
                dix_q  <= idx_q;
                scnt_q <= sym_q;
            end
        end
    end

    assign lts_found  = found_q;
    assign dout       = dout_q;
    assign dout_vld   = dvld_q;
    assign dout_last  = dlast_q;
    assign sym_start  = sstart_q;
    assign dout_index = dix_q;
    assign sym_cnt    = scnt_q;

`ifdef LTS_SYNC_DBG_EN
    assign corr_metric = m_q;
    assign peak1       = anc;
`else
    // Debug metric and anchor pulse are not exported in this build.
`endif

endmodule

// File: doc/lts_sync.md
# lts_sync

Receive-side long-training-symbol synchroniser for the OFDM baseband. It consumes the complex sample stream produced by the transmit preamble/symbol chain, in the format {Im[15:8], Re[7:0]}. It cross-correlates the stream against the sign-quantised 64-sample time-domain LTS and confirms the preamble by finding two correlation peaks 64 samples apart. After lock it re-emits the data samples with OFDM symbol framing (80 samples per symbol: 16-sample CP plus 64).

## Interface
- THRESH, 2000: unsigned correlation-metric threshold (17-bit).
- TOL, 1: allowed deviation of the peak-to-peak distance from 64 samples.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous and active-low.
- din  in  16  sample {Im, Re}, each a two's-complement 8-bit value.
- din_vld  in  1  sample valid. No backpressure.
- din_last  in  1  last sample of the packet; qualified by din_vld.
- lts_found  out  1  one-cycle pulse when the second LTS peak is confirmed.
- dout  out  16  delayed sample (post-LTS data only).
- dout_vld  out  1  dout valid.
- dout_last  out  1  delayed din_last.
- sym_start  out  1  marks dout of sample 0 (CP start) of each data symbol.
- dout_index  out  7  sample index within the symbol, 0..79.
- sym_cnt  out  8  data symbol number; wraps at 255.

## Operation
- Reference: s[k] = sgn(Re)+j·sgn(Im) of LTS samples k=0..63. The table is identical to the transmit LTS table. A value of 0 maps to +1.
- Delay line: 64×16-bit shift register, shifted only on din_vld. Window w[k] = sample accepted 63−k samples ago.
- Correlation: C = Σ w[k]·conj(s[k]).
  - Cr = Σ(wr·sr + wi·si).
  - Ci = Σ(wi·sr − wr·si).
  - Computed in 16-bit signed, sign-extended with no overflow possible.
- Metric: M = |Cr|+|Ci|, 17-bit unsigned. It is registered on the cycle after the accepting cycle and held when din_vld=0.
- FSM states:
  - SEARCH: when M > THRESH, go to PEAK1 with D=0 and Mpk=M.
  - PEAK1: D counts accepted samples since the anchor.
    - D in 1..63−TOL−1 with M>THRESH and M>Mpk: re-anchor, setting D=0 and Mpk=M.
    - D in 64−TOL..64+TOL with M>THRESH: pulse lts_found, go to LOCKED (first qualifying sample wins).
    - D > 64+TOL: go to SEARCH.
  - LOCKED: each accepted sample is forwarded. dout_index counts 0..79 and wraps. sym_start fires when dout_index=0. sym_cnt increments at each wrap of 79 to 0, starting from 0.
  - On an accepted din_last in LOCKED: output dout_last with that sample, then go to SEARCH. dout_index and sym_cnt clear to 0.
- Samples are not forwarded in SEARCH or PEAK1. A din_last in those states clears the FSM to SEARCH.
- din_vld=0 freezes the delay line, D, the metric, and the counters.

## Timing
- Reset values: lts_found=0, dout=0, dout_vld=0, dout_last=0, sym_start=0, dout_index=0, sym_cnt=0, FSM=SEARCH, delay line all 0.
- Metric latency: 1 cycle after sample acceptance.
- lts_found latency: 2 cycles after acceptance of the peak sample.
- Data path latency: din→dout is 2 cycles. The first sample accepted after the confirming peak is the first dout, with sym_start=1 and dout_index=0.
- Reset asserted mid-packet: all state clears on the next clk edge. A lock is not retained.
- Simultaneous din_last and a confirming peak on the same sample: lts_found pulses, FSM returns to SEARCH, and no dout is produced.

## Configuration
- LTS_SYNC_DBG_EN defined: adds output ports corr_metric[16:0] (registered M) and peak1 (one-cycle pulse on each anchor or re-anchor, aligned with corr_metric).
- LTS_SYNC_DBG_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Ideal preamble with continuous din_vld: 32-sample CP, 2×64 LTS, then 3 data symbols of 80 samples with din_last on the final sample.
  - Peaks at samples 95 and 159.
  - lts_found 2 cycles after sample 159.
  - 240 dout beats, sym_start on beats 0/80/160, sym_cnt 0→2, dout_last on beat 239.
- Same stream with din_vld toggling 1010…: same peak sample indices, same output count, outputs spaced by the input gaps.
- Random ±40 noise only (2000 samples): M never exceeds 2000, lts_found never asserted, dout_vld never asserted.
- Single LTS period followed by 70 noise samples: a PEAK1 entry occurs (peak1 pulse with DBG), then return to SEARCH at D=66 with no lts_found.
- LTS with a 1-sample gap inserted between the periods (D=65): lock achieved. With a 3-sample gap (D=67): no lock.
- rst_n low for 1 cycle at data beat 50: all outputs 0 next cycle. The rest of the packet produces no dout.
